// File: rtl/square_unit_pkg.sv
// square_unit_pkg: shared state encoding, default width and derived-width helpers for square_unit.
package square_unit_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int DEF_WIDTH = 8;
  function automatic int res_w(input int w);
    return 2 * w;
  endfunction
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/square_unit_datapath.sv
// square_datapath: shift-and-add squarer datapath, one partial product per step.
// Ports: clk/rst_n clock and async active-low reset; valor_i operand; load_i
// captures the operand and clears acc/count; step_i adds one partial product;
// wr_result_i loads square_o with the final sum; last_o flags the final step.
module square_datapath
  import square_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        valor_i,
  input  logic                    load_i,
  input  logic                    step_i,
  input  logic                    wr_result_i,
  output logic                    last_o,
  output logic [res_w(WIDTH)-1:0] square_o
);
  localparam int RW = res_w(WIDTH);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [RW-1:0]    mcand, acc, addend;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  always_comb begin
    addend = mplier[0] ? mcand : '0;
    last_o = count == LAST;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      square_o <= '0;
    end else begin
      if (load_i) begin
        mcand  <= {{WIDTH{1'b0}}, valor_i};
        mplier <= valor_i;
        acc    <= '0;
        count  <= '0;
      end else if (step_i) begin
        acc    <= acc + addend;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
      end
      // The final partial product is folded in directly, so square_o is
      // complete on the same edge the FSM enters DONE.
      if (wr_result_i) square_o <= acc + addend;
    end
  end
endmodule

// File: rtl/square_unit.sv
// square_unit: iterative unsigned squarer with start/ready handshake.
// Ports: clk/rst_n clock and async active-low reset; valor_i operand sampled
// on acceptance; start_i request (honoured only in IDLE); busy_o high outside
// IDLE; ready_o one-cycle completion pulse; square_o last completed square.
module square_unit
  import square_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        valor_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    ready_o,
  output logic [res_w(WIDTH)-1:0] square_o
);
  state_t state, next;
  logic load, step, wr_result, last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    load      = (state == IDLE) && start_i;
    step      = state == CALC;
    wr_result = step && last;
    next      = (state == IDLE) ? (start_i ? CALC : IDLE) :
                (state == CALC) ? (last ? DONE : CALC) : IDLE;
  end
  // Outputs depend on the state register only, never on inputs.
  assign busy_o  = state != IDLE;
  assign ready_o = state == DONE;
  square_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk(clk),
    .rst_n(rst_n),
    .valor_i(valor_i),
    .load_i(load),
    .step_i(step),
    .wr_result_i(wr_result),
    .last_o(last),
    .square_o(square_o)
  );
endmodule
